writeback_stage: RTL and testbench
==================================

Name: writeback_stage

Overview:
- Final stage of the three-stage pipeline; sits directly upstream of the register file and drives its write port (reg_wr_E, waddr, wdata).
- Latches the retiring instruction from execute and selects the writeback source: ALU, load data, PC+4 or CSR read data.
- Waits for a multi-cycle data-memory load response, with a stall handshake and a timeout.
- Provides operand forwarding of the in-flight write to the decode-side register read.

Parameters:
- DATA_W, 32, datapath width.
- REG_AW, 5, register address width.
- MEM_TIMEOUT, 16, maximum cycles spent in WAIT before a load is abandoned (range 1..255).

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- ex_valid  in  1  execute stage presents a retiring instruction.
- ex_reg_wr  in  1  instruction writes rd.
- ex_rd  in  REG_AW  destination register.
- ex_wb_sel  in  2  source select: 00 ALU, 01 MEM, 10 PC+4, 11 CSR.
- ex_ld_fmt  in  3  funct3 of load: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- ex_addr_lo  in  2  load address bits [1:0].
- ex_alu_result  in  DATA_W  ALU result.
- ex_pc  in  DATA_W  instruction PC.
- ex_csr_rdata  in  DATA_W  CSR old value.
- dmem_rvalid  in  1  load data valid (one-cycle pulse).
- dmem_rdata  in  DATA_W  raw aligned memory word.
- rs1, rs2  in  REG_AW  decode read addresses.
- rf_rdata1, rf_rdata2  in  DATA_W  register file read data.
- fwd_rdata1, fwd_rdata2  out  DATA_W  forwarded operands to execute.
- reg_wr_E  out  1  register file write enable.
- waddr  out  REG_AW  register file write address.
- wdata  out  DATA_W  register file write data.
- stall  out  1  upstream must hold its instruction.
- load_err  out  1  one-cycle pulse on load timeout.

Behaviour:
- Reset (async, rst_n=0):
  - State is IDLE.
  - reg_wr_E, waddr, wdata, load_err and the timeout counter are all 0.
  - stall is 0.
- States and transitions:
  - IDLE, WRITE, WAIT.
  - capture = ex_valid && !stall, evaluated at each posedge.
  - In IDLE or WRITE:
    - capture with ex_wb_sel==01 -> WAIT; counter cleared.
    - capture with any other ex_wb_sel -> WRITE.
    - no capture -> IDLE.
  - In WAIT:
    - dmem_rvalid=1 -> WRITE with formatted load data.
    - counter==MEM_TIMEOUT-1 with no rvalid -> IDLE; load_err pulses 1 for the next cycle; no write.
    - otherwise counter+1.
- stall = (state==WAIT), combinational. ex_* inputs are ignored while stall=1; upstream holds them.
- Write outputs are registered and update on the capturing or completing posedge:
  - Non-load: reg_wr_E=1 exactly one cycle after capture, i.e. write latency 1.
  - Load: reg_wr_E=1 the cycle after the rvalid posedge.
  - reg_wr_E is a one-cycle pulse unless back-to-back captures occur.
  - Outside a write cycle, reg_wr_E=0 and waddr/wdata hold their last value.
- reg_wr_E = ex_reg_wr && (ex_rd != 0). x0 is never written; waddr still loads ex_rd.
- wdata source by ex_wb_sel:
  - ALU: ex_alu_result.
  - PC+4: ex_pc + 4, modulo 2^DATA_W (0xFFFFFFFC wraps to 0).
  - CSR: ex_csr_rdata.
- Load formatting (fmt and addr_lo are latched at capture):
  - LB/LBU: byte at addr_lo, sign- or zero-extended.
  - LH/LHU: halfword at addr_lo[1]; addr_lo[0] is ignored; sign- or zero-extended.
  - LW: full word; addr_lo is ignored.
  - Undefined fmt: treated as LW.
- dmem_rvalid outside WAIT is ignored.
- Forwarding (combinational):
  - fwd_rdata1 = (reg_wr_E && waddr==rs1 && rs1!=0) ? wdata : rf_rdata1.
  - fwd_rdata2 is the same rule using rs2 and rf_rdata2.
- Back-to-back: a capture during WRITE is legal. The next write follows immediately, so reg_wr_E stays 1 for consecutive cycles.
- Reset asserted mid-WAIT aborts the load: no write and no load_err.

Test Plan:
- ALU instruction, rd=5, result 0x1234_5678, captured at cycle 0 -> cycle 1: reg_wr_E=1, waddr=5, wdata=0x12345678; cycle 2: reg_wr_E=0.
- LB, addr_lo=3, dmem_rdata=0x80FF_FF7F, rvalid 3 cycles after capture -> stall=1 for 3 cycles, then write of 0xFFFFFF80. Repeat as LBU -> 0x00000080. LHU with addr_lo=2 -> 0x000080FF.
- Load with no rvalid, MEM_TIMEOUT=16 -> stall high for 16 cycles, load_err pulse, no write, return to IDLE; a later rvalid is ignored.
- ex_rd=0 with ex_reg_wr=1, ALU result 0xDEAD_BEEF -> reg_wr_E stays 0; fwd_rdata1 with rs1=0 equals rf_rdata1.
- Back-to-back PC+4 at pc=0xFFFF_FFFC (rd=1), then CSR read 0xA5 (rd=1) -> wdata 0x0 then 0xA5 on consecutive cycles; rs1=1 forwards each value while rf_rdata1=0x77.
- rst_n pulled low during WAIT -> all outputs 0 immediately (async); after release, state IDLE and stall=0.

Source files
------------

// File: rtl/writeback_stage.sv
// Writeback stage: latches the retiring instruction, selects the write source,
// waits for load data with a timeout, and forwards the in-flight write to decode.
module writeback_stage #(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 5,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic              ex_reg_wr,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [1:0]        ex_wb_sel,
  input  logic [2:0]        ex_ld_fmt,
  input  logic [1:0]        ex_addr_lo,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_pc,
  input  logic [DATA_W-1:0] ex_csr_rdata,
  input  logic              dmem_rvalid,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  output logic [DATA_W-1:0] fwd_rdata1,
  output logic [DATA_W-1:0] fwd_rdata2,
  output logic              reg_wr_E,
  output logic [REG_AW-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic              stall,
  output logic              load_err
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_WAIT} state_e;
  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4, WB_CSR} wb_sel_e;
  typedef enum logic [2:0] {
    LD_B = 3'b000, LD_H = 3'b001, LD_W = 3'b010, LD_BU = 3'b100, LD_HU = 3'b101
  } ld_fmt_e;

  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                reg_wr_q, reg_wr_d;
  logic [REG_AW-1:0]   waddr_q, waddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                load_err_q, load_err_d;
  logic [REG_AW-1:0]   pend_rd_q, pend_rd_d;
  logic                pend_wr_q, pend_wr_d;
  logic [2:0]          pend_fmt_q, pend_fmt_d;
  logic [1:0]          pend_lo_q, pend_lo_d;

  logic                capture;
  logic [7:0]          ld_byte;
  logic [15:0]         ld_half;
  logic [DATA_W-1:0]   ld_data;
  logic [DATA_W-1:0]   src_data;

  // Load formatting uses the fmt/addr_lo latched at capture, not the live ex_* inputs.
  always_comb begin
    ld_byte = '0;
    ld_half = '0;
    ld_data = '0;
    case (pend_lo_q)
      2'd0:    ld_byte = dmem_rdata[7:0];
      2'd1:    ld_byte = dmem_rdata[15:8];
      2'd2:    ld_byte = dmem_rdata[23:16];
      default: ld_byte = dmem_rdata[31:24];
    endcase
    ld_half = pend_lo_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (ld_fmt_e'(pend_fmt_q))
      LD_B:    ld_data = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
      LD_BU:   ld_data = {{(DATA_W-8){1'b0}}, ld_byte};
      LD_H:    ld_data = {{(DATA_W-16){ld_half[15]}}, ld_half};
      LD_HU:   ld_data = {{(DATA_W-16){1'b0}}, ld_half};
      default: ld_data = dmem_rdata;
    endcase
  end

  always_comb begin
    src_data = ex_alu_result;
    case (wb_sel_e'(ex_wb_sel))
      WB_PC4:  src_data = ex_pc + DATA_W'(4);
      WB_CSR:  src_data = ex_csr_rdata;
      default: src_data = ex_alu_result;
    endcase
  end

  assign capture = ex_valid && (state_q != S_WAIT);

  always_comb begin
    state_d    = S_IDLE;
    cnt_d      = cnt_q;
    reg_wr_d   = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    load_err_d = 1'b0;
    pend_rd_d  = pend_rd_q;
    pend_wr_d  = pend_wr_q;
    pend_fmt_d = pend_fmt_q;
    pend_lo_d  = pend_lo_q;
    case (state_q)
      S_IDLE, S_WRITE: begin
        if (capture) begin
          if (wb_sel_e'(ex_wb_sel) == WB_MEM) begin
            state_d    = S_WAIT;
            cnt_d      = '0;
            pend_rd_d  = ex_rd;
            pend_wr_d  = ex_reg_wr && (ex_rd != '0);
            pend_fmt_d = ex_ld_fmt;
            pend_lo_d  = ex_addr_lo;
          end else begin
            state_d  = S_WRITE;
            reg_wr_d = ex_reg_wr && (ex_rd != '0);
            waddr_d  = ex_rd;
            wdata_d  = src_data;
          end
        end
      end
      S_WAIT: begin
        if (dmem_rvalid) begin
          state_d  = S_WRITE;
          reg_wr_d = pend_wr_q;
          waddr_d  = pend_rd_q;
          wdata_d  = ld_data;
        end else if (cnt_q == TMO_LAST) begin
          state_d    = S_IDLE;
          load_err_d = 1'b1;
        end else begin
          state_d = S_WAIT;
          cnt_d   = cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      reg_wr_q   <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      load_err_q <= 1'b0;
      pend_rd_q  <= '0;
      pend_wr_q  <= 1'b0;
      pend_fmt_q <= '0;
      pend_lo_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      reg_wr_q   <= reg_wr_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      load_err_q <= load_err_d;
      pend_rd_q  <= pend_rd_d;
      pend_wr_q  <= pend_wr_d;
      pend_fmt_q <= pend_fmt_d;
      pend_lo_q  <= pend_lo_d;
    end
  end

  assign reg_wr_E = reg_wr_q;
  assign waddr    = waddr_q;
  assign wdata    = wdata_q;
  assign load_err = load_err_q;
  assign stall    = (state_q == S_WAIT);

  assign fwd_rdata1 = (reg_wr_q && (waddr_q == rs1) && (rs1 != '0)) ? wdata_q : rf_rdata1;
  assign fwd_rdata2 = (reg_wr_q && (waddr_q == rs2) && (rs2 != '0)) ? wdata_q : rf_rdata2;

endmodule

// File: tb/tb_writeback_stage.sv
// Testbench for writeback_stage: scenario tasks with inline checks plus a
// scoreboard of expected register-file writes consumed by a write monitor.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_reg_wr;
  logic [4:0]  ex_rd;
  logic [1:0]  ex_wb_sel;
  logic [2:0]  ex_ld_fmt;
  logic [1:0]  ex_addr_lo;
  logic [31:0] ex_alu_result, ex_pc, ex_csr_rdata;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic [4:0]  rs1, rs2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic [31:0] fwd_rdata1, fwd_rdata2;
  logic        reg_wr_E;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        stall, load_err;

  int checks = 0;
  int errors = 0;
  logic [36:0] exp_q[$];

  always #5 clk = ~clk;

  writeback_stage #(.DATA_W(32), .REG_AW(5), .MEM_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_reg_wr(ex_reg_wr),
    .ex_rd(ex_rd), .ex_wb_sel(ex_wb_sel), .ex_ld_fmt(ex_ld_fmt),
    .ex_addr_lo(ex_addr_lo), .ex_alu_result(ex_alu_result), .ex_pc(ex_pc),
    .ex_csr_rdata(ex_csr_rdata), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .rs1(rs1), .rs2(rs2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .fwd_rdata1(fwd_rdata1), .fwd_rdata2(fwd_rdata2), .reg_wr_E(reg_wr_E),
    .waddr(waddr), .wdata(wdata), .stall(stall), .load_err(load_err)
  );

  // Every observed write must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n && reg_wr_E) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_write: got waddr=%0d wdata=%h, expected no write", waddr, wdata);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        if ({waddr, wdata} !== e) begin
          errors++;
          $display("FAIL sb_write: got waddr=%0d wdata=%h, expected waddr=%0d wdata=%h",
                   waddr, wdata, e[36:32], e[31:0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid = 0; ex_reg_wr = 0; ex_rd = 0; ex_wb_sel = 0; ex_ld_fmt = 0;
    ex_addr_lo = 0; ex_alu_result = 0; ex_pc = 0; ex_csr_rdata = 0;
    dmem_rvalid = 0; dmem_rdata = 0; rs1 = 0; rs2 = 0; rf_rdata1 = 0; rf_rdata2 = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    #12;
    checks++;
    if ({reg_wr_E, waddr, wdata, load_err, stall} !== 40'd0) begin
      errors++;
      $display("FAIL reset_outputs: got wr=%b waddr=%0d wdata=%h err=%b stall=%b, expected all 0",
               reg_wr_E, waddr, wdata, load_err, stall);
    end
    step();
    rst_n = 1;
    step();
  endtask

  task automatic test_alu();
    ex_valid = 1; ex_reg_wr = 1; ex_rd = 5; ex_wb_sel = 2'b00; ex_alu_result = 32'h1234_5678;
    exp_q.push_back({5'd5, 32'h1234_5678});
    step();
    ex_valid = 0;
    checks++;
    if (reg_wr_E !== 1'b1 || waddr !== 5'd5 || wdata !== 32'h1234_5678) begin
      errors++;
      $display("FAIL alu_write: got wr=%b waddr=%0d wdata=%h, expected 1/5/12345678", reg_wr_E, waddr, wdata);
    end
    step();
    checks++;
    if (reg_wr_E !== 1'b0 || wdata !== 32'h1234_5678) begin
      errors++;
      $display("FAIL alu_pulse: got wr=%b wdata=%h, expected 0/12345678 held", reg_wr_E, wdata);
    end
  endtask

  task automatic test_load(input logic [2:0] fmt, input logic [1:0] lo, input logic [4:0] rd,
                           input logic [31:0] raw, input logic [31:0] expd);
    ex_valid = 1; ex_reg_wr = 1; ex_rd = rd; ex_wb_sel = 2'b01; ex_ld_fmt = fmt; ex_addr_lo = lo;
    exp_q.push_back({rd, expd});
    step();
    // Garbage on ex_* during the stall must not disturb the pending load.
    ex_ld_fmt = 3'b010; ex_addr_lo = 2'b00; ex_rd = 5'd31; ex_wb_sel = 2'b00;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (stall !== 1'b1 || reg_wr_E !== 1'b0) begin
        errors++;
        $display("FAIL load_stall fmt=%b cyc=%0d: got stall=%b wr=%b, expected 1/0", fmt, i, stall, reg_wr_E);
      end
      if (i < 2) step();
    end
    dmem_rvalid = 1; dmem_rdata = raw;
    ex_valid = 0;
    step();
    dmem_rvalid = 0;
    checks++;
    if (stall !== 1'b0 || reg_wr_E !== 1'b1 || waddr !== rd || wdata !== expd) begin
      errors++;
      $display("FAIL load_data fmt=%b lo=%0d: got stall=%b wr=%b waddr=%0d wdata=%h, expected 0/1/%0d/%h",
               fmt, lo, stall, reg_wr_E, waddr, wdata, rd, expd);
    end
    step();
  endtask

  task automatic test_timeout();
    int n = 0;
    ex_valid = 1; ex_reg_wr = 1; ex_rd = 9; ex_wb_sel = 2'b01; ex_ld_fmt = 3'b010;
    step();
    ex_valid = 0;
    while (stall === 1'b1 && n < 40) begin
      n++;
      step();
    end
    checks++;
    if (n !== 16) begin
      errors++;
      $display("FAIL timeout_stall_cycles: got %0d, expected 16", n);
    end
    checks++;
    if (load_err !== 1'b1 || reg_wr_E !== 1'b0) begin
      errors++;
      $display("FAIL timeout_err: got load_err=%b wr=%b, expected 1/0", load_err, reg_wr_E);
    end
    dmem_rvalid = 1; dmem_rdata = 32'hCAFE_F00D;
    step();
    dmem_rvalid = 0;
    checks++;
    if (load_err !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL timeout_err_pulse: got load_err=%b stall=%b, expected 0/0", load_err, stall);
    end
    step();
    checks++;
    if (reg_wr_E !== 1'b0) begin
      errors++;
      $display("FAIL late_rvalid_ignored: got wr=%b, expected 0", reg_wr_E);
    end
  endtask

  task automatic test_x0();
    ex_valid = 1; ex_reg_wr = 1; ex_rd = 0; ex_wb_sel = 2'b00; ex_alu_result = 32'hDEAD_BEEF;
    rs1 = 0; rf_rdata1 = 32'h1111_2222;
    step();
    ex_valid = 0;
    checks++;
    if (reg_wr_E !== 1'b0 || waddr !== 5'd0) begin
      errors++;
      $display("FAIL x0_write: got wr=%b waddr=%0d, expected 0/0", reg_wr_E, waddr);
    end
    checks++;
    if (fwd_rdata1 !== 32'h1111_2222) begin
      errors++;
      $display("FAIL x0_fwd: got %h, expected 11112222", fwd_rdata1);
    end
    step();
  endtask

  task automatic test_back_to_back();
    rs1 = 1; rf_rdata1 = 32'h77; rs2 = 2; rf_rdata2 = 32'h55;
    ex_valid = 1; ex_reg_wr = 1; ex_rd = 1; ex_wb_sel = 2'b10; ex_pc = 32'hFFFF_FFFC;
    exp_q.push_back({5'd1, 32'h0});
    step();
    ex_wb_sel = 2'b11; ex_csr_rdata = 32'hA5;
    exp_q.push_back({5'd1, 32'hA5});
    checks++;
    if (reg_wr_E !== 1'b1 || wdata !== 32'h0 || fwd_rdata1 !== 32'h0 || fwd_rdata2 !== 32'h55) begin
      errors++;
      $display("FAIL b2b_pc4: got wr=%b wdata=%h fwd1=%h fwd2=%h, expected 1/0/0/55",
               reg_wr_E, wdata, fwd_rdata1, fwd_rdata2);
    end
    step();
    ex_valid = 0;
    checks++;
    if (reg_wr_E !== 1'b1 || wdata !== 32'hA5 || fwd_rdata1 !== 32'hA5) begin
      errors++;
      $display("FAIL b2b_csr: got wr=%b wdata=%h fwd1=%h, expected 1/a5/a5", reg_wr_E, wdata, fwd_rdata1);
    end
    step();
    checks++;
    if (reg_wr_E !== 1'b0 || fwd_rdata1 !== 32'h77) begin
      errors++;
      $display("FAIL b2b_end: got wr=%b fwd1=%h, expected 0/77", reg_wr_E, fwd_rdata1);
    end
  endtask

  task automatic test_reset_in_wait();
    ex_valid = 1; ex_reg_wr = 1; ex_rd = 7; ex_wb_sel = 2'b01; ex_ld_fmt = 3'b010;
    step();
    ex_valid = 0;
    step();
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL rst_wait_entry: got stall=%b, expected 1", stall);
    end
    #2 rst_n = 0;
    #1;
    checks++;
    if ({reg_wr_E, waddr, wdata, load_err, stall} !== 40'd0) begin
      errors++;
      $display("FAIL rst_async: got wr=%b waddr=%0d wdata=%h err=%b stall=%b, expected all 0",
               reg_wr_E, waddr, wdata, load_err, stall);
    end
    step();
    rst_n = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (i == 0 || i == 19) begin
        checks++;
        if (stall !== 1'b0 || load_err !== 1'b0 || reg_wr_E !== 1'b0) begin
          errors++;
          $display("FAIL rst_release cyc=%0d: got stall=%b err=%b wr=%b, expected 0/0/0",
                   i, stall, load_err, reg_wr_E);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load(3'b000, 2'd3, 5'd6,  32'h80FF_FF7F, 32'hFFFF_FF80);
    test_load(3'b100, 2'd3, 5'd6,  32'h80FF_FF7F, 32'h0000_0080);
    test_load(3'b101, 2'd2, 5'd8,  32'h80FF_FF7F, 32'h0000_80FF);
    test_load(3'b001, 2'd1, 5'd10, 32'h80FF_FF7F, 32'hFFFF_FF7F);
    test_load(3'b010, 2'd3, 5'd11, 32'h80FF_FF7F, 32'h80FF_FF7F);
    test_load(3'b011, 2'd1, 5'd12, 32'h1357_9BDF, 32'h1357_9BDF);
    test_timeout();
    test_x0();
    test_back_to_back();
    test_reset_in_wait();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending writes, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
